motor_driver: RTL
=================

# motor_driver

Converts the 3-bit drive command from the line-tracking sensor FSM into PWM and H-bridge direction signals for the kart's left and right motors. Sits between the tracker's `state` output and the motor driver IC pins. It adds:
- a per-wheel duty ramp (soft start and soft stop);
- a ramp-down plus brake dead-time on every direction reversal, so a FORWARD→BACKWARD or LEFT→BACKLEFT transition never hard-reverses the motors.

## Interface
- PWM_BITS, 8: PWM counter and duty width.
- FWD_DUTY, 200: duty of the outer/straight wheel.
- TURN_DUTY, 60: duty of the inner wheel on a turn.
- RAMP_STEP, 20: duty change per ramp tick.
- RAMP_DIV, 4: ms_clk cycles per ramp tick.
- DEAD_TICKS, 50: ms_clk cycles of brake held between directions.

- ms_clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high.
- state, input, 3: drive command.
  - STOP=000, FORWARD=001, LEFT=010, RIGHT=011, BACKWARD=101, BACKLEFT=110, BACKRIGHT=111.
  - 100 is treated as STOP.
- left_pwm, output, 1: left motor enable PWM.
- right_pwm, output, 1: right motor enable PWM.
- left_dir, output, 2: left H-bridge {IN1,IN2}. 10=fwd, 01=rev, 00=coast, 11=brake.
- right_dir, output, 2: right H-bridge, same encoding.

## Operation
Command decode to per-wheel target {dir, duty}:
- FORWARD: both fwd, FWD_DUTY.
- BACKWARD: both rev, FWD_DUTY.
- LEFT: left fwd TURN_DUTY, right fwd FWD_DUTY.
- RIGHT: left fwd FWD_DUTY, right fwd TURN_DUTY.
- BACKLEFT / BACKRIGHT: as LEFT / RIGHT with rev.
- STOP / 100: target duty 0, no target direction.

Ramp tick: a shared counter counts 0..RAMP_DIV-1 and pulses `tick` on wrap. On each tick, cur_duty moves toward the effective target by RAMP_STEP, saturating exactly at the target with no overshoot. Width is PWM_BITS+1 internally, clamped to 0..2^PWM_BITS-1.

Per-wheel FSM, states RUN, DECEL, DEAD, COAST:
- COAST (dir=00, cur_duty=0):
  - a nonzero target → dir=target dir, go to RUN in the same cycle; ramp up from 0.
- RUN:
  - same target dir → ramp toward target duty.
  - STOP → ramp to 0; on cur_duty==0 go to COAST.
  - opposite dir → go to DECEL.
- DECEL:
  - effective target 0, keep current dir.
  - on cur_duty==0 → DEAD, load dead counter = DEAD_TICKS-1.
  - if the command returns to the current dir before reaching 0 → back to RUN.
  - STOP → COAST on reaching 0.
- DEAD:
  - dir=11, duty 0, count down; DEAD always runs to completion.
  - at 0: nonzero target → set dir to the target dir at that moment, go to RUN; STOP → COAST.

PWM:
- A shared free-running PWM_BITS counter wraps 2^PWM_BITS-1 → 0.
- pwm = (pwm_cnt < cur_duty). Duty 0 gives constant low.

The command is sampled every cycle; there is no handshake. Each wheel is independent, so on LEFT→BACKWARD both wheels reverse, each with its own DECEL/DEAD timing.

## Timing
- Reset: every output 0 (pwm low, dir 00). FSMs in COAST, all counters 0, cur_duty 0.
- Reset mid-DEAD or mid-ramp aborts immediately to the reset state.
- Command registered once; dir outputs change 1 cycle after the command is registered.
- COAST→RUN: dir valid 2 cycles after `state` changes. First nonzero duty on the next tick.
- Ramp 0→FWD_DUTY takes ceil(200/20)=10 ticks = 40 cycles at defaults.
- Reversal from full speed: 10 ticks of DECEL, then DEAD_TICKS cycles of brake, then ramp.
- All outputs registered; no combinational path from `state` to any pin.

## Structure
- Shared package `kart_defs`: the seven command localparams (one source for this block and the tracker) and the dir codes FWD/REV/COAST/BRAKE.
- Sub-module `motor_channel`, instantiated twice:
  - ports: target_dir, target_duty, tick, pwm_cnt; outputs dir and pwm.
  - contains the FSM, cur_duty and dead counter.
- Top level holds the command register, decode, ramp-tick counter and PWM counter.

## Test plan
- Reset, then FORWARD → both dir=10 after 2 cycles; duty steps 20,40,…,200 at every 4th cycle; pwm high for 200 of every 256 cycles.
- Steady FORWARD, then LEFT → left duty ramps 200→60 in 7 ticks (last step saturates); right stays 200; dirs unchanged.
- FORWARD at 200, then BACKWARD → both ramp to 0 with dir=10, then dir=11 for exactly 50 cycles, then dir=01 and ramp to 200.
- FORWARD at 200, then STOP → duty reaches 0 after 10 ticks, then dir=00. pwm never high after duty hits 0.
- Mid-DECEL (duty 100), command back to FORWARD → returns to RUN and ramps to 200 with no DEAD phase. Mid-DEAD, command FORWARD → DEAD completes 50 cycles, then dir=10.
- Code 100 behaves as STOP. Reset asserted mid-DEAD → all outputs 0 asynchronously.

Source files
------------

// File: rtl/kart_defs.sv
// Shared kart definitions: drive command codes, H-bridge direction codes, channel states.
package kart_defs;

    localparam logic [2:0] CMD_STOP      = 3'b000;
    localparam logic [2:0] CMD_FORWARD   = 3'b001;
    localparam logic [2:0] CMD_LEFT      = 3'b010;
    localparam logic [2:0] CMD_RIGHT     = 3'b011;
    localparam logic [2:0] CMD_BACKWARD  = 3'b101;
    localparam logic [2:0] CMD_BACKLEFT  = 3'b110;
    localparam logic [2:0] CMD_BACKRIGHT = 3'b111;

    // H-bridge {IN1,IN2}
    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_REV   = 2'b01;
    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    typedef enum logic [1:0] {
        CH_COAST = 2'd0,
        CH_RUN   = 2'd1,
        CH_DECEL = 2'd2,
        CH_DEAD  = 2'd3
    } ch_state_e;

endpackage

// File: rtl/motor_channel.sv
// One wheel: duty ramp, reversal sequencing (decel, brake dead-time) and PWM compare.
module motor_channel
    import kart_defs::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned RAMP_STEP  = 20,
    parameter int unsigned DEAD_TICKS = 50
) (
    input  logic                ms_clk,
    input  logic                reset,
    input  logic [1:0]          target_dir,
    input  logic [PWM_BITS-1:0] target_duty,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [1:0]          dir,
    output logic                pwm
);

    localparam int unsigned DW     = PWM_BITS + 1;
    localparam int unsigned DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [DW-1:0] STEP = DW'(RAMP_STEP);
    localparam logic [DW-1:0] MAXD = {1'b0, {PWM_BITS{1'b1}}};

    ch_state_e           state_q, state_d;
    logic [1:0]          dir_q, dir_d;
    logic [PWM_BITS-1:0] cur_duty_q, cur_duty_d;
    logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
    logic                pwm_q, pwm_d;

    logic [DW-1:0] cur_x, eff_x, ramp_x;

    // Next duty one ramp step toward the effective target, saturating at the target
    always_comb begin
        eff_x  = '0;
        if (state_q == CH_RUN && target_duty != '0 && target_dir == dir_q) begin
            eff_x = {1'b0, target_duty};
        end
        cur_x  = {1'b0, cur_duty_q};
        ramp_x = cur_x;
        if (cur_x < eff_x) begin
            ramp_x = (cur_x + STEP > eff_x) ? eff_x : cur_x + STEP;
        end else if (cur_x > eff_x) begin
            ramp_x = (cur_x > eff_x + STEP) ? cur_x - STEP : eff_x;
        end
        if (ramp_x > MAXD) begin
            ramp_x = MAXD;
        end
    end

    // Channel FSM: next state, direction, duty, dead counter and PWM compare
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        dead_cnt_d = dead_cnt_q;
        cur_duty_d = tick ? ramp_x[PWM_BITS-1:0] : cur_duty_q;
        pwm_d      = (pwm_cnt < cur_duty_q);
        case (state_q)
            CH_COAST: begin
                dir_d = DIR_COAST;
                if (target_duty != '0) begin
                    dir_d   = target_dir;
                    state_d = CH_RUN;
                end
            end
            CH_RUN: begin
                if (target_duty == '0) begin
                    if (cur_duty_q == '0) begin
                        dir_d   = DIR_COAST;
                        state_d = CH_COAST;
                    end
                end else if (target_dir != dir_q) begin
                    state_d = CH_DECEL;
                end
            end
            CH_DECEL: begin
                if (target_duty != '0 && target_dir == dir_q) begin
                    state_d = CH_RUN;
                end else if (cur_duty_q == '0) begin
                    if (target_duty == '0) begin
                        dir_d   = DIR_COAST;
                        state_d = CH_COAST;
                    end else begin
                        dir_d      = DIR_BRAKE;
                        dead_cnt_d = DEAD_W'(DEAD_TICKS - 1);
                        state_d    = CH_DEAD;
                    end
                end
            end
            CH_DEAD: begin
                cur_duty_d = '0;
                if (dead_cnt_q == '0) begin
                    if (target_duty != '0) begin
                        dir_d   = target_dir;
                        state_d = CH_RUN;
                    end else begin
                        dir_d   = DIR_COAST;
                        state_d = CH_COAST;
                    end
                end else begin
                    dead_cnt_d = dead_cnt_q - 1'b1;
                end
            end
            default: begin
                dir_d   = DIR_COAST;
                state_d = CH_COAST;
            end
        endcase
    end

    // Channel state registers
    always_ff @(posedge ms_clk or posedge reset) begin
        if (reset) begin
            state_q    <= CH_COAST;
            dir_q      <= DIR_COAST;
            cur_duty_q <= '0;
            dead_cnt_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cur_duty_q <= cur_duty_d;
            dead_cnt_q <= dead_cnt_d;
            pwm_q      <= pwm_d;
        end
    end

    assign dir = dir_q;
    assign pwm = pwm_q;

endmodule

// File: rtl/motor_driver.sv
// Drive command to per-wheel PWM/H-bridge: command register, decode, shared ramp tick and PWM counter.
module motor_driver
    import kart_defs::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned FWD_DUTY   = 200,
    parameter int unsigned TURN_DUTY  = 60,
    parameter int unsigned RAMP_STEP  = 20,
    parameter int unsigned RAMP_DIV   = 4,
    parameter int unsigned DEAD_TICKS = 50
) (
    input  logic       ms_clk,
    input  logic       reset,
    input  logic [2:0] state,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir
);

    localparam int unsigned TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] FWD_D  = PWM_BITS'(FWD_DUTY);
    localparam logic [PWM_BITS-1:0] TURN_D = PWM_BITS'(TURN_DUTY);

    logic [2:0]          cmd_q, cmd_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                tick_c;

    logic [1:0]          l_tdir_c, r_tdir_c;
    logic [PWM_BITS-1:0] l_tduty_c, r_tduty_c;

    // Command sampling, ramp-tick divider and free-running PWM counter
    always_comb begin
        cmd_d      = state;
        tick_c     = (tick_cnt_q == TICK_W'(RAMP_DIV - 1));
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + 1'b1;
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
    end

    // Registered command to per-wheel target direction and duty
    always_comb begin
        l_tdir_c  = DIR_COAST;
        r_tdir_c  = DIR_COAST;
        l_tduty_c = '0;
        r_tduty_c = '0;
        case (cmd_q)
            CMD_FORWARD: begin
                l_tdir_c = DIR_FWD; r_tdir_c = DIR_FWD;
                l_tduty_c = FWD_D;  r_tduty_c = FWD_D;
            end
            CMD_BACKWARD: begin
                l_tdir_c = DIR_REV; r_tdir_c = DIR_REV;
                l_tduty_c = FWD_D;  r_tduty_c = FWD_D;
            end
            CMD_LEFT: begin
                l_tdir_c = DIR_FWD; r_tdir_c = DIR_FWD;
                l_tduty_c = TURN_D; r_tduty_c = FWD_D;
            end
            CMD_RIGHT: begin
                l_tdir_c = DIR_FWD; r_tdir_c = DIR_FWD;
                l_tduty_c = FWD_D;  r_tduty_c = TURN_D;
            end
            CMD_BACKLEFT: begin
                l_tdir_c = DIR_REV; r_tdir_c = DIR_REV;
                l_tduty_c = TURN_D; r_tduty_c = FWD_D;
            end
            CMD_BACKRIGHT: begin
                l_tdir_c = DIR_REV; r_tdir_c = DIR_REV;
                l_tduty_c = FWD_D;  r_tduty_c = TURN_D;
            end
            CMD_STOP: ;
            default: ;
        endcase
    end

    // Top-level registers
    always_ff @(posedge ms_clk or posedge reset) begin
        if (reset) begin
            cmd_q      <= CMD_STOP;
            tick_cnt_q <= '0;
            pwm_cnt_q  <= '0;
        end else begin
            cmd_q      <= cmd_d;
            tick_cnt_q <= tick_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
        end
    end

    motor_channel #(
        .PWM_BITS   (PWM_BITS),
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_left (
        .ms_clk      (ms_clk),
        .reset       (reset),
        .target_dir  (l_tdir_c),
        .target_duty (l_tduty_c),
        .tick        (tick_c),
        .pwm_cnt     (pwm_cnt_q),
        .dir         (left_dir),
        .pwm         (left_pwm)
    );

    motor_channel #(
        .PWM_BITS   (PWM_BITS),
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_right (
        .ms_clk      (ms_clk),
        .reset       (reset),
        .target_dir  (r_tdir_c),
        .target_duty (r_tduty_c),
        .tick        (tick_c),
        .pwm_cnt     (pwm_cnt_q),
        .dir         (right_dir),
        .pwm         (right_pwm)
    );

endmodule
